cancel_accum_ctrl: RTL and testbench
====================================

Name: cancel_accum_ctrl

Overview:
- Read-modify-write sequencer that owns the dual-port cancelled-order accumulator RAM (address = client ID, data = accumulated cancelled value).
- Zero-fills the RAM after reset or on request, then accumulates cancel events per client with saturation.
- Arbitrates between cancel updates and client-value queries, sharing the single read port.
- Sits between the order-cancel decode stage and the RAM instance, alongside a downstream query/report path.

Parameters:
- D_WIDTH, 32, accumulator and cancel-value width.
- A_WIDTH, 4, client-ID width.
- A_MAX, 16, number of clients (2^A_WIDTH).

Ports:
- clk  input  1  single clock; RAM write and read clocks are both tied to it.
- reset  input  1  synchronous, active-high reset.
- cxl_valid  input  1  cancel event present.
- cxl_ready  output  1  cancel event accepted when cxl_valid & cxl_ready.
- cxl_client  input  A_WIDTH  client ID of the cancel.
- cxl_value  input  D_WIDTH  cancelled amount to add.
- qry_valid  input  1  query request present.
- qry_ready  output  1  query accepted when qry_valid & qry_ready.
- qry_client  input  A_WIDTH  client ID to read.
- rsp_valid  output  1  one-cycle pulse carrying the query result.
- rsp_data  output  D_WIDTH  accumulated value for the queried client.
- clear_req  input  1  pulse: zero the whole RAM.
- busy  output  1  high while in CLEAR.
- sat_flag  output  1  sticky; set when any accumulation saturated.
- ram_address_write  output  A_WIDTH  to RAM write address.
- ram_data_write  output  D_WIDTH  to RAM write data.
- ram_write_enable  output  1  to RAM write enable.
- ram_address_read  output  A_WIDTH  to RAM read address.
- ram_data_read  input  D_WIDTH  from RAM; valid 1 cycle after the address is presented.

Behaviour:
- Reset values: all outputs 0, except busy=1. State=CLEAR, clear counter=0, sat_flag=0, priority pointer=cancel-first.
- CLEAR state:
  - Each cycle writes 0 to address=counter (ram_write_enable=1); counter increments.
  - After writing A_MAX-1, go to IDLE.
  - Lasts exactly A_MAX cycles.
  - cxl_ready=qry_ready=0.
- IDLE state:
  - cxl_ready=1 and qry_ready=1 are combinationally gated by the arbiter.
  - Only one request is granted per cycle.
  - When both valid: grant per round-robin pointer; the pointer flips to the other requester after each contested grant. Uncontested grants leave the pointer unchanged.
  - Grant cancel: drive ram_address_read=cxl_client, latch client and value, go to UPDATE.
  - Grant query: drive ram_address_read=qry_client, latch client, go to RESP.
- UPDATE state (1 cycle):
  - sum = ram_data_read + latched value, computed at D_WIDTH+1 bits.
  - If the carry is set: write all-ones and set sat_flag. Otherwise write sum[D_WIDTH-1:0].
  - ram_write_enable=1 at the latched client; return to IDLE.
- RESP state (1 cycle): rsp_valid=1, rsp_data=ram_data_read; return to IDLE.
- Throughput: one operation per 2 cycles. Both ready outputs are 0 in UPDATE and RESP.
- No hazard logic needed: a write in UPDATE completes before the next read is issued.
- Latency: query accepted in cycle N → rsp_valid in cycle N+1.
- Outside CLEAR and UPDATE, ram_write_enable=0.
- clear_req:
  - Sampled in IDLE only, and takes precedence over both requests in that cycle.
  - Enters CLEAR and resets sat_flag.
  - Ignored in other states; it is not queued.
- reset asserted mid-operation aborts any in-flight RMW; no write is issued for it, and the block restarts CLEAR.
- ram_address_read/write hold their last value when unused.
- Request inputs are don't-care when the matching ready is 0.

Test Plan:
- Reset, hold cxl_valid=1 → 16 zero-writes on addresses 0..15, busy falls after cycle 16, first cxl_ready=1 in cycle 17; query every client → all 0.
- Cancels client 3 +100, client 3 +250 back-to-back, then query 3 → rsp_data=350, rsp_valid exactly 1 cycle after the query accept.
- Cancel client 5 +0xFFFFFFF0, then +0x20 → stored 0xFFFFFFFF, sat_flag=1. Query client 5 → 0xFFFFFFFF.
- cxl_valid and qry_valid held continuously → grants alternate cancel/query, each every 2 cycles, with no starvation. Query results reflect prior cancels.
- After accumulating on clients 1 and 2, pulse clear_req in IDLE together with cxl_valid → cancel not accepted, CLEAR runs 16 cycles, sat_flag=0, queries return 0.
- Assert reset in the cycle after a cancel accept (state UPDATE) → no RAM write that cycle, CLEAR restarts, busy=1.

Source files
------------

// File: rtl/cancel_accum_ctrl.sv
// Read-modify-write sequencer for the cancelled-order accumulator RAM.
// Zero-fills the RAM, then arbitrates saturating cancel updates against value queries.
module cancel_accum_ctrl #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 4,
  parameter int A_MAX   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cxl_valid,
  output logic               cxl_ready,
  input  logic [A_WIDTH-1:0] cxl_client,
  input  logic [D_WIDTH-1:0] cxl_value,
  input  logic               qry_valid,
  output logic               qry_ready,
  input  logic [A_WIDTH-1:0] qry_client,
  output logic               rsp_valid,
  output logic [D_WIDTH-1:0] rsp_data,
  input  logic               clear_req,
  output logic               busy,
  output logic               sat_flag,
  output logic [A_WIDTH-1:0] ram_address_write,
  output logic [D_WIDTH-1:0] ram_data_write,
  output logic               ram_write_enable,
  output logic [A_WIDTH-1:0] ram_address_read,
  input  logic [D_WIDTH-1:0] ram_data_read
);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [A_WIDTH-1:0] CLR_LAST = A_WIDTH'(A_MAX - 1);

  state_t             state_reg, state_next;
  logic [A_WIDTH-1:0] clr_cnt_reg, clr_cnt_next;
  logic [A_WIDTH-1:0] client_reg, client_next;
  logic [D_WIDTH-1:0] value_reg, value_next;
  logic               sat_reg, sat_next;
  logic               cxl_first_reg, cxl_first_next;
  logic [A_WIDTH-1:0] rd_addr_reg, rd_addr_next;
  logic [A_WIDTH-1:0] wr_addr_reg, wr_addr_next;
  logic [D_WIDTH:0]   sum;
  logic               grant_cxl;
  logic               grant_qry;

  assign sat_flag = sat_reg;

  always_comb begin
    state_next        = state_reg;
    clr_cnt_next      = clr_cnt_reg;
    client_next       = client_reg;
    value_next        = value_reg;
    sat_next          = sat_reg;
    cxl_first_next    = cxl_first_reg;
    rd_addr_next      = rd_addr_reg;
    wr_addr_next      = wr_addr_reg;
    grant_cxl         = 1'b0;
    grant_qry         = 1'b0;
    cxl_ready         = 1'b0;
    qry_ready         = 1'b0;
    rsp_valid         = 1'b0;
    rsp_data          = '0;
    busy              = 1'b0;
    ram_write_enable  = 1'b0;
    ram_data_write    = '0;
    ram_address_write = wr_addr_reg;
    ram_address_read  = rd_addr_reg;
    sum               = {1'b0, ram_data_read} + {1'b0, value_reg};

    case (state_reg)
      ST_CLEAR: begin
        busy              = 1'b1;
        ram_write_enable  = 1'b1;
        ram_address_write = clr_cnt_reg;
        wr_addr_next      = clr_cnt_reg;
        clr_cnt_next      = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == CLR_LAST) begin
          clr_cnt_next = '0;
          state_next   = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (clear_req) begin
          clr_cnt_next = '0;
          sat_next     = 1'b0;
          state_next   = ST_CLEAR;
        end else begin
          // Round-robin pointer only moves when both sides actually compete.
          if (cxl_valid && qry_valid) begin
            grant_cxl      = cxl_first_reg;
            grant_qry      = ~cxl_first_reg;
            cxl_first_next = ~cxl_first_reg;
          end else begin
            grant_cxl = cxl_valid;
            grant_qry = qry_valid;
          end

          if (grant_cxl) begin
            cxl_ready        = 1'b1;
            ram_address_read = cxl_client;
            rd_addr_next     = cxl_client;
            client_next      = cxl_client;
            value_next       = cxl_value;
            state_next       = ST_UPDATE;
          end else if (grant_qry) begin
            qry_ready        = 1'b1;
            ram_address_read = qry_client;
            rd_addr_next     = qry_client;
            client_next      = qry_client;
            state_next       = ST_RESP;
          end
        end
      end

      ST_UPDATE: begin
        ram_write_enable  = 1'b1;
        ram_address_write = client_reg;
        wr_addr_next      = client_reg;
        if (sum[D_WIDTH]) begin
          ram_data_write = '1;
          sat_next       = 1'b1;
        end else begin
          ram_data_write = sum[D_WIDTH-1:0];
        end
        state_next = ST_IDLE;
      end

      ST_RESP: begin
        rsp_valid  = 1'b1;
        rsp_data   = ram_data_read;
        state_next = ST_IDLE;
      end

      default: state_next = ST_CLEAR;
    endcase

    // An in-flight RMW is abandoned on reset, so nothing may reach the RAM that cycle.
    if (reset) begin
      cxl_ready         = 1'b0;
      qry_ready         = 1'b0;
      rsp_valid         = 1'b0;
      rsp_data          = '0;
      ram_write_enable  = 1'b0;
      ram_data_write    = '0;
      ram_address_write = '0;
      ram_address_read  = '0;
      busy              = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_CLEAR;
      clr_cnt_reg   <= '0;
      client_reg    <= '0;
      value_reg     <= '0;
      sat_reg       <= 1'b0;
      cxl_first_reg <= 1'b1;
      rd_addr_reg   <= '0;
      wr_addr_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      clr_cnt_reg   <= clr_cnt_next;
      client_reg    <= client_next;
      value_reg     <= value_next;
      sat_reg       <= sat_next;
      cxl_first_reg <= cxl_first_next;
      rd_addr_reg   <= rd_addr_next;
      wr_addr_reg   <= wr_addr_next;
    end
  end

endmodule

// File: tb/tb_cancel_accum_ctrl.sv
// Scoreboard bench for cancel_accum_ctrl with a behavioural registered-read RAM.
module tb_cancel_accum_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int AM = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cxl_valid, cxl_ready;
  logic [AW-1:0] cxl_client;
  logic [DW-1:0] cxl_value;
  logic          qry_valid, qry_ready;
  logic [AW-1:0] qry_client;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          clear_req, busy, sat_flag;
  logic [AW-1:0] ram_address_write, ram_address_read;
  logic [DW-1:0] ram_data_write, ram_data_read;
  logic          ram_write_enable;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] mem   [AM];
  logic [DW-1:0] model [AM];
  logic [DW-1:0] exp_q [$];
  logic          rsp_due = 1'b0;
  logic [DW:0]   msum;

  always #5 clk = ~clk;

  cancel_accum_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(AM)) dut (
    .clk               (clk),
    .reset             (reset),
    .cxl_valid         (cxl_valid),
    .cxl_ready         (cxl_ready),
    .cxl_client        (cxl_client),
    .cxl_value         (cxl_value),
    .qry_valid         (qry_valid),
    .qry_ready         (qry_ready),
    .qry_client        (qry_client),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .clear_req         (clear_req),
    .busy              (busy),
    .sat_flag          (sat_flag),
    .ram_address_write (ram_address_write),
    .ram_data_write    (ram_data_write),
    .ram_write_enable  (ram_write_enable),
    .ram_address_read  (ram_address_read),
    .ram_data_read     (ram_data_read)
  );

  // RAM starts with junk so the zero-fill is visible through queries.
  initial begin
    for (int i = 0; i < AM; i++) mem[i] = 32'hDEAD_BEEF;
    ram_data_read = '0;
  end

  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address_write] <= ram_data_write;
    ram_data_read <= mem[ram_address_read];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s got=%0h t=%0t", tag, got, $time);
    end
  endtask

  // Monitor: model update on cancel accept, push expectation on query accept.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      rsp_due = 1'b0;
      for (int i = 0; i < AM; i++) model[i] = '0;
    end else begin
      if (rsp_due || rsp_valid) check("rsp_latency", rsp_valid, rsp_due);
      if (rsp_valid && exp_q.size() > 0) check("rsp_data", rsp_data, exp_q.pop_front());
      if (cxl_ready || qry_ready) check("one_grant", cxl_ready & qry_ready, 0);
      rsp_due = 1'b0;
      if (cxl_valid && cxl_ready) begin
        msum = {1'b0, model[cxl_client]} + {1'b0, cxl_value};
        model[cxl_client] = msum[DW] ? {DW{1'b1}} : msum[DW-1:0];
      end
      if (qry_valid && qry_ready) begin
        exp_q.push_back(model[qry_client]);
        rsp_due = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cancel(input logic [AW-1:0] c, input logic [DW-1:0] v);
    logic ok = 1'b0;
    cxl_valid = 1'b1; cxl_client = c; cxl_value = v;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = cxl_ready;
      tick();
    end
    cxl_valid = 1'b0;
    check("cxl_accept", ok, 1);
  endtask

  task automatic do_query(input logic [AW-1:0] c);
    logic ok = 1'b0;
    qry_valid = 1'b1; qry_client = c;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = qry_ready;
      tick();
    end
    qry_valid = 1'b0;
    check("qry_accept", ok, 1);
  endtask

  task automatic clear_sweep();
    for (int i = 0; i < AM; i++) begin
      @(negedge clk);
      check("clr_busy", busy, 1);
      check("clr_we", ram_write_enable, 1);
      check("clr_addr", ram_address_write, i);
      check("clr_data", ram_data_write, 0);
      check("clr_cxl_ready", cxl_ready, 0);
      tick();
    end
  endtask

  initial begin
    logic expect_cxl;
    int   grants;
    reset = 1'b1; clear_req = 1'b0;
    cxl_valid = 1'b1; cxl_client = '0; cxl_value = '0;
    qry_valid = 1'b0; qry_client = '0;

    // Reset, then zero-fill with a cancel already waiting.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_cxl_ready", cxl_ready, 0);
    check("rst_we", ram_write_enable, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    tick();
    reset = 1'b0;
    clear_sweep();
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("first_cxl_ready", cxl_ready, 1);
    tick();
    cxl_valid = 1'b0;
    for (int c = 0; c < AM; c++) do_query(AW'(c));

    // Back-to-back accumulation on client 3.
    do_cancel(4'd3, 32'd100);
    do_cancel(4'd3, 32'd250);
    do_query(4'd3);

    // Saturation on client 5.
    do_cancel(4'd5, 32'hFFFF_FFF0);
    do_cancel(4'd5, 32'h0000_0020);
    tick();
    @(negedge clk);
    check("sat_set", sat_flag, 1);
    do_query(4'd5);

    // Contested requests alternate, starting with cancel.
    cxl_client = 4'd7; cxl_value = 32'd5; qry_client = 4'd7;
    cxl_valid = 1'b1; qry_valid = 1'b1;
    expect_cxl = 1'b1;
    grants = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (cxl_ready || qry_ready) begin
        check("rr_order", cxl_ready, expect_cxl);
        expect_cxl = ~expect_cxl;
        grants++;
      end
      tick();
    end
    cxl_valid = 1'b0; qry_valid = 1'b0;
    check("rr_grants", grants, 12);
    tick();

    // Clear request beats a simultaneous cancel.
    do_cancel(4'd1, 32'd11);
    do_cancel(4'd2, 32'd22);
    tick();
    clear_req = 1'b1; cxl_valid = 1'b1; cxl_client = 4'd1; cxl_value = 32'd1;
    @(negedge clk);
    check("clr_blocks_cxl", cxl_ready, 0);
    tick();
    clear_req = 1'b0; cxl_valid = 1'b0;
    for (int i = 0; i < AM; i++) model[i] = '0;
    clear_sweep();
    @(negedge clk);
    check("clr_done_busy", busy, 0);
    check("clr_sat", sat_flag, 0);
    do_query(4'd1);
    do_query(4'd2);

    // Reset during UPDATE must suppress the write.
    do_cancel(4'd4, 32'd9);
    reset = 1'b1;
    @(negedge clk);
    check("rmw_abort_we", ram_write_enable, 0);
    check("rmw_abort_busy", busy, 1);
    tick();
    reset = 1'b0;
    clear_sweep();
    do_query(4'd4);

    repeat (4) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
